// File: rtl/pwm_core.sv
// Multi-channel PWM generator with prescaler, edge/center-aligned counting,
// and shadowed period/compare/mode registers that reload only at update events.
module pwm_core #(
  parameter int CHN_NUM   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PSC_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         mode_i,
  input  logic [PSC_WIDTH-1:0]         psc_i,
  input  logic [CNT_WIDTH-1:0]         arr_i,
  input  logic [CHN_NUM*CNT_WIDTH-1:0] cmp_i,
  input  logic [CHN_NUM-1:0]           pol_i,
  input  logic [CHN_NUM-1:0]           chen_i,
  input  logic                         irq_en_i,
  input  logic                         irq_clr_i,
  output logic [CNT_WIDTH-1:0]         cnt_o,
  output logic [CHN_NUM-1:0]           pwm_o,
  output logic                         irq_o
);

  logic [PSC_WIDTH-1:0]         psc_cnt_q, psc_cnt_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]         arr_s_q, arr_s_d, arr_e;
  logic [CHN_NUM*CNT_WIDTH-1:0] cmp_s_q, cmp_s_d, cmp_e;
  logic                         mode_s_q, mode_s_d, mode_e;
  logic                         dir_q, dir_d;
  logic                         en_q;
  logic                         irq_q, irq_d;
  logic [CHN_NUM-1:0]           pwm_q, pwm_d;
  logic                         first, tick, evt;

  // On the first enabled cycle the shadows are still stale, so the live
  // inputs stand in for them; this keeps the first period exact.
  assign first  = en_i & ~en_q;
  assign arr_e  = first ? arr_i  : arr_s_q;
  assign cmp_e  = first ? cmp_i  : cmp_s_q;
  assign mode_e = first ? mode_i : mode_s_q;

  assign tick = en_i && (psc_cnt_q >= psc_i);
  assign evt  = tick && (mode_e ? (cnt_q == '0) : (cnt_q >= arr_e));

  always_comb begin
    psc_cnt_d = '0;
    cnt_d     = '0;
    dir_d     = 1'b0;
    arr_s_d   = arr_s_q;
    cmp_s_d   = cmp_s_q;
    mode_s_d  = mode_s_q;
    if (en_i) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      if (tick) begin
        if (!mode_e) begin
          cnt_d = evt ? '0 : cnt_q + 1'b1;
          dir_d = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d = (arr_e == '0) ? '0 : CNT_WIDTH'(1);
          dir_d = 1'b0;
        end else if (!dir_q && (cnt_q < arr_e)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          dir_d = 1'b1;
        end
      end
      if (first || evt) begin
        arr_s_d  = arr_i;
        cmp_s_d  = cmp_i;
        mode_s_d = mode_i;
      end
    end
  end

  // A set arriving with a clear wins, so no event is ever lost.
  assign irq_d = (evt & irq_en_i) | (irq_q & ~irq_clr_i);

  generate
    for (genvar gi = 0; gi < CHN_NUM; gi++) begin : g_chn
      assign pwm_d[gi] = (en_i && chen_i[gi])
                       ? ((cnt_q < cmp_e[gi*CNT_WIDTH +: CNT_WIDTH]) ^ pol_i[gi])
                       : pol_i[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_cnt_q <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      arr_s_q   <= '0;
      cmp_s_q   <= '0;
      mode_s_q  <= 1'b0;
      en_q      <= 1'b0;
      irq_q     <= 1'b0;
      pwm_q     <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      arr_s_q   <= arr_s_d;
      cmp_s_q   <= cmp_s_d;
      mode_s_q  <= mode_s_d;
      en_q      <= en_i;
      irq_q     <= irq_d;
      pwm_q     <= pwm_d;
    end
  end

  assign cnt_o = cnt_q;
  assign pwm_o = pwm_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core: expected cnt/pwm/irq per cycle are derived
// from closed-form period formulas and compared at the falling clock edge.
module tb_pwm_core;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, mode_i, irq_en_i, irq_clr_i;
  logic [15:0] psc_i, arr_i;
  logic [63:0] cmp_i;
  logic [3:0]  pol_i, chen_i;
  logic [15:0] cnt_o;
  logic [3:0]  pwm_o;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         cnt;
    logic [3:0] pwm;
    logic       irq;
  } exp_t;
  exp_t sb_q[$];

  pwm_core #(.CHN_NUM(4), .CNT_WIDTH(16), .PSC_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
    .psc_i(psc_i), .arr_i(arr_i), .cmp_i(cmp_i), .pol_i(pol_i),
    .chen_i(chen_i), .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i),
    .cnt_o(cnt_o), .pwm_o(pwm_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Triangle counter value after t ticks for center mode with top a.
  function automatic int tri_f(int t, int a);
    int r;
    r = t % (2 * a);
    return (r <= a) ? r : 2 * a - r;
  endfunction

  task automatic reset_dut();
    rst_i = 1'b1; en_i = 1'b0; irq_clr_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Apply a configuration while disabled, then enable at a falling edge.
  task automatic cfg(input logic m, input int psc, input int arr,
                     input logic [63:0] cmp, input logic [3:0] pol,
                     input logic [3:0] chen, input logic ien);
    reset_dut();
    mode_i = m; psc_i = 16'(psc); arr_i = 16'(arr); cmp_i = cmp;
    pol_i = pol; chen_i = chen; irq_en_i = ien;
    @(negedge clk_i);
    @(negedge clk_i);
    en_i = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_i = 1'b1; en_i = 1'b1; pol_i = 4'hF; chen_i = 4'hF;
    @(negedge clk_i);
    e = '{cnt: 0, pwm: 4'h0, irq: 1'b0};
    n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=%0d", cnt_o, e.cnt); end
    n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL reset_pwm got=%b exp=%b", pwm_o, e.pwm); end
    n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL reset_irq got=%b exp=%b", irq_o, e.irq); end
    $display("[TB] reset: cnt=%0d pwm=%b irq=%b", cnt_o, pwm_o, irq_o);
  endtask

  task automatic test_edge();
    exp_t e;
    cfg(1'b0, 0, 9, {48'd0, 16'd3}, 4'h0, 4'hF, 1'b0);
    for (int j = 0; j < 25; j++) begin
      sb_q.push_back('{cnt: (j + 1) % 10, pwm: {3'b000, (j % 10) < 3}, irq: 1'b0});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL edge_cnt j=%0d got=%0d exp=%0d", j, cnt_o, e.cnt); end
      n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL edge_pwm j=%0d got=%b exp=%b", j, pwm_o, e.pwm); end
      $display("[TB] edge j=%0d cnt=%0d pwm=%b", j, cnt_o, pwm_o);
    end
  endtask

  task automatic test_center();
    exp_t e;
    cfg(1'b1, 1, 4, {48'd0, 16'd2}, 4'h0, 4'hF, 1'b0);
    for (int j = 0; j < 40; j++) begin
      sb_q.push_back('{cnt: tri_f((j + 1) / 2, 4),
                       pwm: {3'b000, tri_f(j / 2, 4) < 2}, irq: 1'b0});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL center_cnt j=%0d got=%0d exp=%0d", j, cnt_o, e.cnt); end
      n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL center_pwm j=%0d got=%b exp=%b", j, pwm_o, e.pwm); end
      $display("[TB] center j=%0d cnt=%0d pwm=%b", j, cnt_o, pwm_o);
    end
  endtask

  task automatic test_shadow();
    exp_t e;
    cfg(1'b0, 0, 9, {48'd0, 16'd3}, 4'h0, 4'hF, 1'b0);
    for (int j = 0; j < 25; j++) begin
      sb_q.push_back('{cnt: (j + 1) % 10,
                       pwm: {3'b000, (j % 10) < ((j < 10) ? 3 : 6)}, irq: 1'b0});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL shadow_cnt j=%0d got=%0d exp=%0d", j, cnt_o, e.cnt); end
      n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL shadow_pwm j=%0d got=%b exp=%b", j, pwm_o, e.pwm); end
      $display("[TB] shadow j=%0d cnt=%0d pwm=%b", j, cnt_o, pwm_o);
      if (j == 3) cmp_i = {48'd0, 16'd6};
    end
  endtask

  task automatic test_boundaries();
    exp_t e;
    // ch0 cmp=0, ch1 cmp>arr, ch2 inverted, ch3 disabled with pol=1
    cfg(1'b0, 0, 9, {16'd3, 16'd3, 16'd10, 16'd0}, 4'b1100, 4'b0111, 1'b0);
    for (int j = 0; j < 20; j++) begin
      sb_q.push_back('{cnt: (j + 1) % 10,
                       pwm: {1'b1, !((j % 10) < 3), 1'b1, 1'b0}, irq: 1'b0});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL bound_pwm j=%0d got=%b exp=%b", j, pwm_o, e.pwm); end
      $display("[TB] bound j=%0d cnt=%0d pwm=%b", j, cnt_o, pwm_o);
    end
  endtask

  task automatic test_arr_zero();
    exp_t e;
    cfg(1'b0, 2, 0, {48'd0, 16'd0}, 4'h0, 4'hF, 1'b1);
    for (int j = 0; j < 12; j++) begin
      irq_clr_i = (j % 3 == 0);
      sb_q.push_back('{cnt: 0, pwm: 4'h0, irq: (j % 3 == 2)});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL arr0_cnt j=%0d got=%0d exp=%0d", j, cnt_o, e.cnt); end
      n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL arr0_irq j=%0d got=%b exp=%b", j, irq_o, e.irq); end
      $display("[TB] arr0 j=%0d cnt=%0d irq=%b", j, cnt_o, irq_o);
    end
    irq_clr_i = 1'b0;
  endtask

  task automatic test_irq();
    exp_t e;
    cfg(1'b0, 0, 3, {48'd0, 16'd2}, 4'h0, 4'hF, 1'b1);
    for (int j = 0; j < 14; j++) begin
      irq_clr_i = (j == 7) || (j == 9);
      sb_q.push_back('{cnt: (j + 1) % 4, pwm: {3'b000, (j % 4) < 2},
                       irq: (j >= 3 && j <= 8) || (j >= 11)});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL irq_cnt j=%0d got=%0d exp=%0d", j, cnt_o, e.cnt); end
      n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL irq_pwm j=%0d got=%b exp=%b", j, pwm_o, e.pwm); end
      n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL irq_pend j=%0d got=%b exp=%b", j, irq_o, e.irq); end
      $display("[TB] irq j=%0d cnt=%0d irq=%b clr=%b", j, cnt_o, irq_o, irq_clr_i);
    end
    irq_clr_i = 1'b0;
  endtask

  task automatic test_reset_enable();
    exp_t e;
    cfg(1'b0, 0, 7, {48'd0, 16'd6}, 4'h0, 4'hF, 1'b1);
    for (int j = 0; j < 13; j++) @(negedge clk_i);
    sb_q.push_back('{cnt: 5, pwm: 4'b0001, irq: 1'b1});
    e = sb_q.pop_front();
    n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL pre_rst_cnt got=%0d exp=%0d", cnt_o, e.cnt); end
    n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL pre_rst_pwm got=%b exp=%b", pwm_o, e.pwm); end
    n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL pre_rst_irq got=%b exp=%b", irq_o, e.irq); end
    rst_i = 1'b1;
    sb_q.push_back('{cnt: 0, pwm: 4'h0, irq: 1'b0});
    #1;
    e = sb_q.pop_front();
    n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL async_rst_cnt got=%0d exp=%0d", cnt_o, e.cnt); end
    n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL async_rst_pwm got=%b exp=%b", pwm_o, e.pwm); end
    n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL async_rst_irq got=%b exp=%b", irq_o, e.irq); end
    $display("[TB] async reset: cnt=%0d pwm=%b irq=%b", cnt_o, pwm_o, irq_o);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int j = 0; j < 6; j++) @(negedge clk_i);
    en_i = 1'b0; pol_i = 4'b1010; irq_en_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      sb_q.push_back('{cnt: 0, pwm: 4'b1010, irq: 1'b0});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL dis_cnt j=%0d got=%0d exp=%0d", j, cnt_o, e.cnt); end
      n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL dis_pwm j=%0d got=%b exp=%b", j, pwm_o, e.pwm); end
      $display("[TB] disabled j=%0d cnt=%0d pwm=%b", j, cnt_o, pwm_o);
    end
    arr_i = 16'd4; cmp_i = {48'd0, 16'd1}; pol_i = 4'h0;
    en_i = 1'b1;
    for (int j = 0; j < 12; j++) begin
      sb_q.push_back('{cnt: (j + 1) % 5, pwm: {3'b000, (j % 5) < 1}, irq: 1'b0});
      @(negedge clk_i);
      e = sb_q.pop_front();
      n_tests++; if (cnt_o !== 16'(e.cnt)) begin n_fail++; $display("FAIL reen_cnt j=%0d got=%0d exp=%0d", j, cnt_o, e.cnt); end
      n_tests++; if (pwm_o !== e.pwm) begin n_fail++; $display("FAIL reen_pwm j=%0d got=%b exp=%b", j, pwm_o, e.pwm); end
      $display("[TB] reenable j=%0d cnt=%0d pwm=%b", j, cnt_o, pwm_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; mode_i = 1'b0; psc_i = '0; arr_i = '0;
    cmp_i = '0; pol_i = '0; chen_i = '0; irq_en_i = 1'b0; irq_clr_i = 1'b0;
    test_reset();
    test_edge();
    test_center();
    test_shadow();
    test_boundaries();
    test_arr_zero();
    test_irq();
    test_reset_enable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
